pc_unit: RTL and testbench

Parametrised program-counter unit for the RV32 core's fetch stage, successor to the single-source `pc`. Holds the architectural fetch PC and each cycle selects the next PC from one of several sources, in fixed priority:
- trap vector
- pipeline redirect
- stall hold
- return-address-stack pop
- taken branch/jump
- sequential increment

Contains a small circular return-address stack (RAS) so `ret` targets are available at fetch without waiting for register read.

---
 rtl/pc_pkg.sv | 15 +
 rtl/pc_ras.sv | 76 +++++++
 rtl/pc_unit.sv | 91 +++++++++
 tb/tb_pc_unit.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared types and constants for the fetch-stage program-counter unit.
package pc_pkg;

  localparam int unsigned INSTR_BYTES = 4;

  typedef enum logic [2:0] {
    PC_SEQ      = 3'd0,
    PC_BRANCH   = 3'd1,
    PC_RET      = 3'd2,
    PC_REDIRECT = 3'd3,
    PC_TRAP     = 3'd4,
    PC_HOLD     = 3'd5
  } pc_src_e;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack; a push when full overwrites the oldest entry.
module pc_ras #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            push,
  input  logic            pop,
  input  logic            replace,
  input  logic            flush,
  input  logic [XLEN-1:0] data,
  output logic [XLEN-1:0] top,
  output logic            empty,
  output logic            full,
  output logic            err_c
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [XLEN-1:0]  mem [DEPTH];
  logic [PTR_W-1:0] ptr, ptr_d, top_idx, wr_idx;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic             wr_en;

  // ptr names the next free slot; the top lives one below it
  assign top_idx = ptr - PTR_W'(1);
  assign top     = mem[top_idx];
  assign empty   = (cnt == CNT_W'(0));
  assign full    = (cnt == CNT_W'(DEPTH));

  always_comb begin
    ptr_d  = ptr;
    cnt_d  = cnt;
    wr_en  = 1'b0;
    wr_idx = ptr;
    err_c  = 1'b0;
    if (flush) begin
      ptr_d = '0;
      cnt_d = '0;
    end else if (replace && !empty) begin
      wr_en  = 1'b1;
      wr_idx = top_idx;
    end else if (push || replace) begin
      // replace on an empty stack degrades to a push plus underflow
      wr_en = 1'b1;
      ptr_d = ptr + PTR_W'(1);
      err_c = full | replace;
      if (!full) cnt_d = cnt + CNT_W'(1);
    end else if (pop) begin
      if (empty) begin
        err_c = 1'b1;
      end else begin
        ptr_d = ptr - PTR_W'(1);
        cnt_d = cnt - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr <= '0;
      cnt <= '0;
    end else begin
      ptr <= ptr_d;
      cnt <= cnt_d;
    end
  end

  // Entry contents are don't-care after reset or flush
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= data;
  end

endmodule

// File: rtl/pc_unit.sv
// Fetch PC register with prioritised next-PC selection and return-address stack.
module pc_unit
  import pc_pkg::*;
#(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(32'h0000_0000),
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0100),
  parameter int unsigned     RAS_DEPTH    = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            trap,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_target,
  input  logic            PCSrc,
  input  logic [XLEN-1:0] branch_target,
  input  logic            is_call,
  input  logic            is_ret,
  output logic [XLEN-1:0] pc_curr,
  output logic [XLEN-1:0] pc_next,
  output logic            ras_empty,
  output logic            ras_full,
  output logic            ras_err
);

  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(INSTR_BYTES - 1);

  pc_src_e         src;
  logic [XLEN-1:0] pc_seq, ras_top;
  logic            ras_act, ras_push, ras_pop, ras_replace, ras_err_c;

  assign pc_seq = pc_curr + XLEN'(INSTR_BYTES);

  // Stack updates only happen on cycles that are neither flushed nor held
  assign ras_act     = !trap && !redirect && !stall;
  assign ras_push    = ras_act && is_call && !is_ret;
  assign ras_pop     = ras_act && is_ret && !is_call;
  assign ras_replace = ras_act && is_call && is_ret;

  always_comb begin
    src = PC_SEQ;
    if (trap)                    src = PC_TRAP;
    else if (redirect)           src = PC_REDIRECT;
    else if (stall)              src = PC_HOLD;
    else if (is_ret && !ras_empty) src = PC_RET;
    else if (PCSrc)              src = PC_BRANCH;
  end

  always_comb begin
    pc_next = pc_seq;
    case (src)
      PC_TRAP:     pc_next = TRAP_VECTOR;
      PC_REDIRECT: pc_next = redirect_target;
      PC_HOLD:     pc_next = pc_curr;
      PC_RET:      pc_next = ras_top;
      PC_BRANCH:   pc_next = branch_target;
      default:     pc_next = pc_seq;
    endcase
    pc_next = pc_next & ALIGN_MASK;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pc_curr <= RESET_VECTOR & ALIGN_MASK;
    else        pc_curr <= pc_next;
  end

  // Sticky overflow/underflow flag, cleared only by reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)         ras_err <= 1'b0;
    else if (ras_err_c) ras_err <= 1'b1;
  end

  pc_ras #(
    .XLEN  (XLEN),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk     (clk),
    .reset   (reset),
    .push    (ras_push | ras_replace),
    .pop     (ras_pop),
    .replace (ras_replace),
    .flush   (trap),
    .data    (pc_seq),
    .top     (ras_top),
    .empty   (ras_empty),
    .full    (ras_full),
    .err_c   (ras_err_c)
  );

endmodule

// File: tb/tb_pc_unit.sv
// Randomised and directed bench for pc_unit against a queue-based reference model.
module tb_pc_unit;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset, stall, trap, redirect, PCSrc, is_call, is_ret;
  logic [31:0] redirect_target, branch_target;
  logic [31:0] pc_curr, pc_next;
  logic        ras_empty, ras_full, ras_err;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  logic [31:0] m_pc  = 32'h0;
  logic [31:0] m_q[$];
  bit          m_err = 1'b0;

  pc_unit #(
    .XLEN         (32),
    .RESET_VECTOR (32'h0000_0000),
    .TRAP_VECTOR  (32'h0000_0100),
    .RAS_DEPTH    (DEPTH)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .stall           (stall),
    .trap            (trap),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .PCSrc           (PCSrc),
    .branch_target   (branch_target),
    .is_call         (is_call),
    .is_ret          (is_ret),
    .pc_curr         (pc_curr),
    .pc_next         (pc_next),
    .ras_empty       (ras_empty),
    .ras_full        (ras_full),
    .ras_err         (ras_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_next();
    if (trap)                         return 32'h100;
    if (redirect)                     return redirect_target & ~32'h3;
    if (stall)                        return m_pc;
    if (is_ret && m_q.size() != 0)    return m_q[m_q.size()-1];
    if (PCSrc)                        return branch_target & ~32'h3;
    return m_pc + 32'd4;
  endfunction

  task automatic m_reset();
    m_pc  = 32'h0;
    m_q.delete();
    m_err = 1'b0;
  endtask

  always @(negedge reset) m_reset();

  // Reference: bounded stack that drops its oldest entry on overflow
  always @(posedge clk) begin
    logic [31:0] nxt, ra;
    if (!reset) begin
      m_reset();
    end else begin
      nxt = m_next();
      ra  = m_pc + 32'd4;
      if (trap) begin
        m_q.delete();
      end else if (!redirect && !stall) begin
        if (is_call && is_ret) begin
          if (m_q.size() == 0) begin
            m_q.push_back(ra);
            m_err = 1'b1;
          end else begin
            m_q[m_q.size()-1] = ra;
          end
        end else if (is_call) begin
          m_q.push_back(ra);
          if (m_q.size() > DEPTH) begin
            void'(m_q.pop_front());
            m_err = 1'b1;
          end
        end else if (is_ret) begin
          if (m_q.size() == 0) m_err = 1'b1;
          else void'(m_q.pop_back());
        end
      end
      m_pc = nxt;
    end
  end

  always @(negedge clk) begin
    if (chk_en && reset) begin
      check("pc_curr", pc_curr, m_pc);
      check("pc_next", pc_next, m_next());
      check("ras_empty", 32'(ras_empty), 32'(m_q.size() == 0));
      check("ras_full", 32'(ras_full), 32'(m_q.size() == DEPTH));
      check("ras_err", 32'(ras_err), 32'(m_err));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    stall = 0; trap = 0; redirect = 0; PCSrc = 0; is_call = 0; is_ret = 0;
    redirect_target = 32'h0; branch_target = 32'h0;
  endtask

  task automatic do_call(input logic [31:0] tgt);
    idle(); is_call = 1; PCSrc = 1; branch_target = tgt;
    cyc();
  endtask

  task automatic do_ret();
    idle(); is_ret = 1;
    cyc();
  endtask

  initial begin
    logic [31:0] rets [4];
    rets[0] = 32'h804; rets[1] = 32'h604; rets[2] = 32'h404; rets[3] = 32'h204;
    reset = 1'b0;
    idle();
    repeat (2) cyc();
    check("rst_pc", pc_curr, 32'h0);
    check("rst_empty", 32'(ras_empty), 32'h1);
    check("rst_full", 32'(ras_full), 32'h0);
    check("rst_err", 32'(ras_err), 32'h0);
    reset  = 1'b1;
    chk_en = 1'b1;
    cyc(); check("inc1", pc_curr, 32'h4);
    cyc(); check("inc2", pc_curr, 32'h8);
    cyc(); check("inc3", pc_curr, 32'hC);

    PCSrc = 1; branch_target = 32'h20;
    cyc(); check("branch", pc_curr, 32'h20);
    stall = 1;
    cyc(); check("stall1", pc_curr, 32'h20);
    cyc(); check("stall2", pc_curr, 32'h20);

    idle(); redirect = 1; redirect_target = 32'h10;
    cyc(); check("redir10", pc_curr, 32'h10);
    do_call(32'h80);
    check("call_pc", pc_curr, 32'h80);
    check("call_nonempty", 32'(ras_empty), 32'h0);
    idle(); cyc();
    check("pc84", pc_curr, 32'h84);
    do_ret();
    check("ret_pc", pc_curr, 32'h14);
    check("ret_empty", 32'(ras_empty), 32'h1);

    for (int i = 1; i <= 5; i++) begin
      do_call(32'(i * 32'h200));
      if (i == 4) check("ovf_noerr", 32'(ras_err), 32'h0);
    end
    check("ovf_full", 32'(ras_full), 32'h1);
    check("ovf_err", 32'(ras_err), 32'h1);
    for (int i = 0; i < 4; i++) begin
      do_ret();
      check("ovf_ret", pc_curr, rets[i]);
    end
    do_ret();
    check("unf_seq", pc_curr, 32'h208);
    check("unf_err", 32'(ras_err), 32'h1);

    do_call(32'h300);
    idle(); trap = 1; redirect = 1; PCSrc = 1; is_ret = 1;
    redirect_target = 32'h500; branch_target = 32'h600;
    cyc();
    check("trap_pc", pc_curr, 32'h100);
    check("trap_flush", 32'(ras_empty), 32'h1);
    idle(); redirect = 1; stall = 1; redirect_target = 32'h43;
    cyc(); check("redir_align", pc_curr, 32'h40);

    idle(); redirect = 1; redirect_target = 32'hFFFF_FFFC;
    cyc(); check("pre_wrap", pc_curr, 32'hFFFF_FFFC);
    idle();
    cyc(); check("wrap", pc_curr, 32'h0);
    cyc();
    #2 reset = 1'b0;
    #1;
    check("async_pc", pc_curr, 32'h0);
    check("async_err", 32'(ras_err), 32'h0);
    check("async_empty", 32'(ras_empty), 32'h1);
    @(posedge clk); #1 reset = 1'b1;
    cyc(); check("post_rst", pc_curr, 32'h4);

    for (int n = 0; n < 3000; n++) begin
      trap            = ($urandom_range(31) == 0);
      redirect        = ($urandom_range(15) == 0);
      stall           = ($urandom_range(7) == 0);
      PCSrc           = ($urandom_range(1) == 0);
      is_call         = ($urandom_range(3) == 0);
      is_ret          = ($urandom_range(3) == 0);
      redirect_target = $urandom();
      branch_target   = $urandom();
      if ($urandom_range(499) == 0) begin
        reset = 1'b0;
        cyc();
        reset = 1'b1;
      end else begin
        cyc();
      end
    end

    idle();
    cyc();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
